// File: rtl/wb_pkg.sv
// Shared write-back definitions.
//   REG_W       register-number width (GPR and CP0 destinations)
//   WB_DATA_W   datapath width carried by a queue entry
//   wb_cond_e   stage condition codes shared with the pipeline controller
//   wb_entry_t  one buffered write-back result with its write requests
package wb_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    COND_FLOW  = 2'd0,
    COND_STALL = 2'd1,
    COND_FLUSH = 2'd2
  } wb_cond_e;

  typedef struct packed {
    logic [REG_W-1:0]     rd;
    logic [WB_DATA_W-1:0] data;
    logic [WB_DATA_W-1:0] hi;
    logic [WB_DATA_W-1:0] lo;
    logic [REG_W-1:0]     cp0_addr;
    logic                 rf_we;
    logic                 hi_we;
    logic                 lo_we;
    logic                 cp0_we;
  } wb_entry_t;

endpackage

// File: rtl/wb_retire_select.sv
// Head-window retire selection for write_back_queue.
//   avail     window slot k holds a valid entry (k < occupancy)
//   rd        packed destination register of each window slot
//   rf_req    slot requests a register-file write
//   spc_req   slot requests any HI/LO/CP0 write
//   take      slot retires this cycle (always a contiguous run from slot 0)
//   rf_en     final register-file enable per port after same-rd suppression
//   n_retire  number of slots retiring
module wb_retire_select
  import wb_pkg::*;
#(
  parameter int unsigned PORTS = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic [PORTS-1:0]       avail,
  input  logic [REG_W*PORTS-1:0] rd,
  input  logic [PORTS-1:0]       rf_req,
  input  logic [PORTS-1:0]       spc_req,
  output logic [PORTS-1:0]       take,
  output logic [PORTS-1:0]       rf_en,
  output logic [CNT_W-1:0]       n_retire
);

  // Scan stops at the first unavailable slot or at a second special writer,
  // so a mult (HI+LO in one entry) still counts as a single special write.
  always_comb begin
    logic stop;
    logic seen_spc;
    take     = '0;
    n_retire = '0;
    stop     = 1'b0;
    seen_spc = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (!stop && avail[i] && !(seen_spc && spc_req[i])) begin
        take[i]  = 1'b1;
        n_retire = n_retire + CNT_W'(1);
        if (spc_req[i]) seen_spc = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // An older write is dropped when a younger retiring entry hits the same rd.
  always_comb begin
    rf_en = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (take[i] && rf_req[i] && (rd[i*REG_W +: REG_W] != '0)) begin
        rf_en[i] = 1'b1;
        for (int unsigned j = i + 1; j < PORTS; j++) begin
          if (take[j] && rf_req[j] && (rd[j*REG_W +: REG_W] == rd[i*REG_W +: REG_W]))
            rf_en[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/write_back_queue.sv
// In-order write-back queue between MEM/WB and the register file, HI/LO, CP0.
// Buffers up to DEPTH results, retires up to RF_PORTS GPR writes plus one
// special (HI/LO/CP0) write per cycle through registered outputs, and answers
// pending-destination lookups over the queued entries.
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        enqueue handshake (in_ready = !full)
//   in_kill                  store entry with all write requests cleared
//   in_rd, in_data, in_hi, in_lo, in_*_we, in_cp0_addr   entry contents
//   flush                    discard all entries and the incoming one
//   rf_we/rf_waddr/rf_wdata  packed register-file write ports
//   hi_*, lo_*, cp0_*        special write outputs
//   q_addr/q_hit/q_data      packed pending-destination lookup ports
//   count, empty, full       occupancy
// DATA_W must match wb_pkg::WB_DATA_W, the width of the stored entry.
module write_back_queue
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RF_PORTS = 2,
  parameter int unsigned NQ       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_kill,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W-1:0]          in_hi,
  input  logic [DATA_W-1:0]          in_lo,
  input  logic                       in_rf_we,
  input  logic                       in_hi_we,
  input  logic                       in_lo_we,
  input  logic                       in_cp0_we,
  input  logic [REG_W-1:0]           in_cp0_addr,
  input  logic                       flush,
  output logic [RF_PORTS-1:0]        rf_we,
  output logic [REG_W*RF_PORTS-1:0]  rf_waddr,
  output logic [DATA_W*RF_PORTS-1:0] rf_wdata,
  output logic                       hi_wena,
  output logic                       lo_wena,
  output logic                       cp0_wena,
  output logic [DATA_W-1:0]          hi_wdata,
  output logic [DATA_W-1:0]          lo_wdata,
  output logic [DATA_W-1:0]          cp0_wdata,
  output logic [REG_W-1:0]           cp0_waddr,
  input  logic [REG_W*NQ-1:0]        q_addr,
  output logic [NQ-1:0]              q_hit,
  output logic [DATA_W*NQ-1:0]       q_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;

  wb_entry_t               in_entry;
  logic                    push;
  wb_entry_t               win_e [RF_PORTS];
  logic [RF_PORTS-1:0]     win_avail;
  logic [REG_W*RF_PORTS-1:0] win_rd;
  logic [RF_PORTS-1:0]     win_rf;
  logic [RF_PORTS-1:0]     win_spc;
  logic [RF_PORTS-1:0]     take;
  logic [RF_PORTS-1:0]     rf_en;
  logic [CW-1:0]           n_retire;

  logic                    hi_sel, lo_sel, cp0_sel;
  logic [DATA_W-1:0]       hi_val, lo_val, cp0_val;
  logic [REG_W-1:0]        cp0_addr_val;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  always_comb begin
    in_entry.rd       = in_rd;
    in_entry.data     = in_data;
    in_entry.hi       = in_hi;
    in_entry.lo       = in_lo;
    in_entry.cp0_addr = in_cp0_addr;
    in_entry.rf_we    = in_rf_we  && !in_kill;
    in_entry.hi_we    = in_hi_we  && !in_kill;
    in_entry.lo_we    = in_lo_we  && !in_kill;
    in_entry.cp0_we   = in_cp0_we && !in_kill;
  end

  for (genvar k = 0; k < RF_PORTS; k++) begin : g_win
    assign win_e[k]                    = mem[head + PW'(k)];
    assign win_avail[k]                = (CW'(k) < cnt);
    assign win_rd[k*REG_W +: REG_W]    = win_e[k].rd;
    assign win_rf[k]                   = win_e[k].rf_we;
    assign win_spc[k]                  = win_e[k].hi_we || win_e[k].lo_we || win_e[k].cp0_we;
  end

  wb_retire_select #(
    .PORTS (RF_PORTS),
    .CNT_W (CW)
  ) u_select (
    .avail    (win_avail),
    .rd       (win_rd),
    .rf_req   (win_rf),
    .spc_req  (win_spc),
    .take     (take),
    .rf_en    (rf_en),
    .n_retire (n_retire)
  );

  // At most one retiring entry carries special requests, so plain OR-select.
  always_comb begin
    hi_sel       = 1'b0;
    lo_sel       = 1'b0;
    cp0_sel      = 1'b0;
    hi_val       = '0;
    lo_val       = '0;
    cp0_val      = '0;
    cp0_addr_val = '0;
    for (int unsigned i = 0; i < RF_PORTS; i++) begin
      if (take[i]) begin
        if (win_e[i].hi_we) begin
          hi_sel = 1'b1;
          hi_val = win_e[i].hi;
        end
        if (win_e[i].lo_we) begin
          lo_sel = 1'b1;
          lo_val = win_e[i].lo;
        end
        if (win_e[i].cp0_we) begin
          cp0_sel      = 1'b1;
          cp0_val      = win_e[i].data;
          cp0_addr_val = win_e[i].cp0_addr;
        end
      end
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0]    idx;
    logic [REG_W-1:0] qa;
    idx    = '0;
    qa     = '0;
    q_hit  = '0;
    q_data = '0;
    for (int unsigned j = 0; j < NQ; j++) begin
      qa = q_addr[j*REG_W +: REG_W];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if ((CW'(k) < cnt) && mem[idx].rf_we && (mem[idx].rd == qa) && (qa != '0)) begin
          q_hit[j]                   = 1'b1;
          q_data[j*DATA_W +: DATA_W] = mem[idx].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      rf_we     <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      hi_wena   <= 1'b0;
      lo_wena   <= 1'b0;
      cp0_wena  <= 1'b0;
      hi_wdata  <= '0;
      lo_wdata  <= '0;
      cp0_wdata <= '0;
      cp0_waddr <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      rf_we    <= '0;
      hi_wena  <= 1'b0;
      lo_wena  <= 1'b0;
      cp0_wena <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= in_entry;
        tail      <= tail + PW'(1);
      end
      head     <= head + PW'(n_retire);
      cnt      <= cnt + CW'(push) - n_retire;
      rf_we    <= rf_en;
      hi_wena  <= hi_sel;
      lo_wena  <= lo_sel;
      cp0_wena <= cp0_sel;
      for (int unsigned i = 0; i < RF_PORTS; i++) begin
        if (take[i]) begin
          rf_waddr[i*REG_W +: REG_W]   <= win_e[i].rd;
          rf_wdata[i*DATA_W +: DATA_W] <= win_e[i].data;
        end
      end
      if (hi_sel) hi_wdata <= hi_val;
      if (lo_sel) lo_wdata <= lo_val;
      if (cp0_sel) begin
        cp0_wdata <= cp0_val;
        cp0_waddr <= cp0_addr_val;
      end
    end
  end

endmodule

// File: tb/tb_write_back_queue.sv
// Self-checking bench for write_back_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_write_back_queue;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RF_PORTS = 2;
  localparam int unsigned NQ       = 2;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_kill;
  logic [4:0]                 in_rd;
  logic [DATA_W-1:0]          in_data, in_hi, in_lo;
  logic                       in_rf_we, in_hi_we, in_lo_we, in_cp0_we;
  logic [4:0]                 in_cp0_addr;
  logic                       flush;
  logic [RF_PORTS-1:0]        rf_we;
  logic [5*RF_PORTS-1:0]      rf_waddr;
  logic [DATA_W*RF_PORTS-1:0] rf_wdata;
  logic                       hi_wena, lo_wena, cp0_wena;
  logic [DATA_W-1:0]          hi_wdata, lo_wdata, cp0_wdata;
  logic [4:0]                 cp0_waddr;
  logic [5*NQ-1:0]            q_addr;
  logic [NQ-1:0]              q_hit;
  logic [DATA_W*NQ-1:0]       q_data;
  logic [CW-1:0]              count;
  logic                       empty, full;

  write_back_queue #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RF_PORTS (RF_PORTS),
    .NQ       (NQ)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_kill (in_kill),
    .in_rd (in_rd), .in_data (in_data), .in_hi (in_hi), .in_lo (in_lo),
    .in_rf_we (in_rf_we), .in_hi_we (in_hi_we), .in_lo_we (in_lo_we),
    .in_cp0_we (in_cp0_we), .in_cp0_addr (in_cp0_addr), .flush (flush),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
    .hi_wena (hi_wena), .lo_wena (lo_wena), .cp0_wena (cp0_wena),
    .hi_wdata (hi_wdata), .lo_wdata (lo_wdata), .cp0_wdata (cp0_wdata),
    .cp0_waddr (cp0_waddr), .q_addr (q_addr), .q_hit (q_hit), .q_data (q_data),
    .count (count), .empty (empty), .full (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data, hi, lo;
    logic [4:0]  ca;
    logic        rf, h, l, c;
  } ment_t;

  ment_t mq[$];
  int checks   = 0;
  int failures = 0;

  logic [RF_PORTS-1:0] e_rf_we;
  logic [4:0]          e_waddr [RF_PORTS];
  logic [31:0]         e_wdata [RF_PORTS];
  logic                e_hi_en, e_lo_en, e_cp0_en;
  logic [31:0]         e_hi, e_lo, e_cp0;
  logic [4:0]          e_cp0_addr;

  function automatic void exp_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (mq[i]) begin
      if (mq[i].rf && mq[i].rd == a && a != 0) begin
        hit = 1'b1;
        d   = mq[i].data;
      end
    end
  endfunction

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_step();
    int n;
    int nspc;
    bit s, wr;
    ment_t e;
    if (!rst) begin
      mq.delete();
      e_rf_we = '0; e_hi_en = 0; e_lo_en = 0; e_cp0_en = 0;
      e_hi = 0; e_lo = 0; e_cp0 = 0; e_cp0_addr = 0;
      for (int i = 0; i < RF_PORTS; i++) begin e_waddr[i] = 0; e_wdata[i] = 0; end
    end else if (flush) begin
      mq.delete();
      e_rf_we = '0; e_hi_en = 0; e_lo_en = 0; e_cp0_en = 0;
    end else begin
      n = 0; nspc = 0;
      while (n < RF_PORTS && n < mq.size()) begin
        s = mq[n].h || mq[n].l || mq[n].c;
        if (s && nspc > 0) break;
        if (s) nspc++;
        n++;
      end
      e_rf_we = '0; e_hi_en = 0; e_lo_en = 0; e_cp0_en = 0;
      for (int i = 0; i < n; i++) begin
        e = mq[i];
        e_waddr[i] = e.rd;
        e_wdata[i] = e.data;
        wr = e.rf && e.rd != 0;
        for (int j = i + 1; j < n; j++)
          if (mq[j].rf && mq[j].rd == e.rd) wr = 0;
        e_rf_we[i] = wr;
        if (e.h) begin e_hi_en = 1; e_hi = e.hi; end
        if (e.l) begin e_lo_en = 1; e_lo = e.lo; end
        if (e.c) begin e_cp0_en = 1; e_cp0 = e.data; e_cp0_addr = e.ca; end
      end
      if (in_valid && mq.size() < DEPTH) begin
        e.rd = in_rd; e.data = in_data; e.hi = in_hi; e.lo = in_lo; e.ca = in_cp0_addr;
        e.rf = in_rf_we && !in_kill; e.h = in_hi_we && !in_kill;
        e.l = in_lo_we && !in_kill;  e.c = in_cp0_we && !in_kill;
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        mq.push_back(e);
      end else begin
        for (int i = 0; i < n; i++) void'(mq.pop_front());
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; in_valid = 0; in_kill = 0; flush = 0;
    in_rf_we = 0; in_hi_we = 0; in_lo_we = 0; in_cp0_we = 0;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] d, input logic rf,
                       input logic h, input logic l, input logic c, input logic [4:0] ca);
    idle();
    in_valid = 1; in_rd = rd; in_data = d; in_hi = d ^ 32'h5555_0000; in_lo = d ^ 32'h0000_AAAA;
    in_rf_we = rf; in_hi_we = h; in_lo_we = l; in_cp0_we = c; in_cp0_addr = ca;
  endtask

  task automatic test_reset();
    idle(); rst = 0; in_valid = 1; in_rd = 5'd3; in_data = 32'hDEAD; in_rf_we = 1;
    q_addr = {5'd3, 5'd7};
    tick();
    idle();
    #1;
    checks++; if (count !== 0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if ({rf_we, hi_wena, lo_wena, cp0_wena} !== '0)
      begin failures++; $display("FAIL reset_enables got=%b exp=0", {rf_we, hi_wena, lo_wena, cp0_wena}); end
    checks++; if ({rf_waddr, rf_wdata, hi_wdata, lo_wdata, cp0_wdata, cp0_waddr} !== '0)
      begin failures++; $display("FAIL reset_wdata got=%h exp=0", {rf_waddr, rf_wdata, hi_wdata, lo_wdata, cp0_wdata, cp0_waddr}); end
    checks++; if (q_hit !== '0)   begin failures++; $display("FAIL reset_qhit got=%b exp=0", q_hit); end
  endtask

  task automatic test_single();
    drive(5'd5, 32'h1234, 1, 0, 0, 0, 0);
    tick();
    idle(); q_addr = {5'd0, 5'd5}; #1;
    checks++; if (count !== 1) begin failures++; $display("FAIL single_count_queued got=%0d exp=1", count); end
    checks++; if (rf_we !== '0) begin failures++; $display("FAIL single_early_we got=%b exp=0", rf_we); end
    checks++; if (q_hit[0] !== 1'b1 || q_data[31:0] !== 32'h1234)
      begin failures++; $display("FAIL single_lookup got=%b/%h exp=1/1234", q_hit[0], q_data[31:0]); end
    tick();
    checks++; if (rf_we !== 2'b01) begin failures++; $display("FAIL single_we got=%b exp=01", rf_we); end
    checks++; if (rf_waddr[4:0] !== 5'd5) begin failures++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr[4:0]); end
    checks++; if (rf_wdata[31:0] !== 32'h1234) begin failures++; $display("FAIL single_wdata got=%h exp=1234", rf_wdata[31:0]); end
    checks++; if (count !== 0 || empty !== 1'b1) begin failures++; $display("FAIL single_drain got=%0d exp=0", count); end
    tick();
    checks++; if (rf_we !== '0 || rf_wdata[31:0] !== 32'h1234)
      begin failures++; $display("FAIL single_hold got=%b/%h exp=00/1234", rf_we, rf_wdata[31:0]); end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) drive(5'(k), 32'h11 * k, 1, 0, 0, 0, 0); else idle();
      #1;
      checks++; if (in_ready !== (mq.size() < DEPTH))
        begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, in_ready, mq.size() < DEPTH); end
      tick();
      checks++; if (rf_we !== e_rf_we || rf_waddr[4:0] !== e_waddr[0] || rf_wdata[31:0] !== e_wdata[0])
        begin failures++; $display("FAIL b2b_port0[%0d] got=%b/%0d/%h exp=%b/%0d/%h", k, rf_we, rf_waddr[4:0], rf_wdata[31:0], e_rf_we, e_waddr[0], e_wdata[0]); end
      checks++; if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH))
        begin failures++; $display("FAIL b2b_count[%0d] got=%0d/%b exp=%0d", k, count, full, mq.size()); end
    end
  endtask

  task automatic test_special();
    drive(5'd0, 32'h0, 0, 1, 1, 0, 0); in_hi = 32'hAAAA; in_lo = 32'hBBBB;
    tick();
    drive(5'd0, 32'hC0C0, 0, 0, 0, 1, 5'd12);
    tick();
    checks++; if ({hi_wena, lo_wena, cp0_wena} !== 3'b110)
      begin failures++; $display("FAIL spc_mult_en got=%b exp=110", {hi_wena, lo_wena, cp0_wena}); end
    checks++; if (hi_wdata !== 32'hAAAA || lo_wdata !== 32'hBBBB)
      begin failures++; $display("FAIL spc_mult_data got=%h/%h exp=aaaa/bbbb", hi_wdata, lo_wdata); end
    idle();
    tick();
    checks++; if ({hi_wena, lo_wena, cp0_wena} !== 3'b001)
      begin failures++; $display("FAIL spc_mtc0_en got=%b exp=001", {hi_wena, lo_wena, cp0_wena}); end
    checks++; if (cp0_waddr !== 5'd12 || cp0_wdata !== 32'hC0C0)
      begin failures++; $display("FAIL spc_mtc0_data got=%0d/%h exp=12/c0c0", cp0_waddr, cp0_wdata); end
    checks++; if (hi_wdata !== 32'hAAAA) begin failures++; $display("FAIL spc_hi_hold got=%h exp=aaaa", hi_wdata); end
  endtask

  task automatic test_same_rd();
    drive(5'd8, 32'hA, 1, 0, 0, 0, 0);
    tick();
    drive(5'd8, 32'hB, 1, 0, 0, 0, 0); q_addr = {5'd0, 5'd8}; #1;
    checks++; if (q_hit !== 2'b01 || q_data[31:0] !== 32'hA)
      begin failures++; $display("FAIL samerd_lookup_a got=%b/%h exp=01/a", q_hit, q_data[31:0]); end
    tick();
    idle(); #1;
    checks++; if (rf_we !== 2'b01 || rf_waddr[4:0] !== 5'd8 || rf_wdata[31:0] !== 32'hA)
      begin failures++; $display("FAIL samerd_first got=%b/%0d/%h exp=01/8/a", rf_we, rf_waddr[4:0], rf_wdata[31:0]); end
    checks++; if (q_hit !== 2'b01 || q_data[31:0] !== 32'hB)
      begin failures++; $display("FAIL samerd_lookup_b got=%b/%h exp=01/b", q_hit, q_data[31:0]); end
    tick();
    checks++; if (rf_we !== 2'b01 || rf_wdata[31:0] !== 32'hB)
      begin failures++; $display("FAIL samerd_second got=%b/%h exp=01/b", rf_we, rf_wdata[31:0]); end
  endtask

  task automatic test_flush();
    drive(5'd3, 32'h33, 1, 1, 0, 0, 0);
    tick();
    drive(5'd9, 32'h99, 1, 0, 0, 1, 5'd4); flush = 1;
    tick();
    checks++; if ({rf_we, hi_wena, cp0_wena} !== '0)
      begin failures++; $display("FAIL flush_no_retire got=%b exp=0", {rf_we, hi_wena, cp0_wena}); end
    checks++; if (count !== 0 || empty !== 1'b1)
      begin failures++; $display("FAIL flush_count got=%0d/%b exp=0/1", count, empty); end
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if ({rf_we, hi_wena, lo_wena, cp0_wena} !== '0)
        begin failures++; $display("FAIL flush_discard[%0d] got=%b exp=0", k, {rf_we, hi_wena, lo_wena, cp0_wena}); end
    end
  endtask

  task automatic test_kill();
    drive(5'd7, 32'h77, 1, 1, 1, 1, 5'd2); in_kill = 1;
    tick();
    idle(); q_addr = {5'd7, 5'd7}; #1;
    checks++; if (count !== 1) begin failures++; $display("FAIL kill_accept got=%0d exp=1", count); end
    checks++; if (q_hit !== '0) begin failures++; $display("FAIL kill_qhit got=%b exp=0", q_hit); end
    tick();
    checks++; if ({rf_we, hi_wena, lo_wena, cp0_wena} !== '0 || count !== 0)
      begin failures++; $display("FAIL kill_retire got=%b/%0d exp=0/0", {rf_we, hi_wena, lo_wena, cp0_wena}, count); end
  endtask

  task automatic test_mid_reset();
    drive(5'd6, 32'h66, 1, 0, 0, 0, 0);
    tick();
    drive(5'd6, 32'h67, 1, 0, 0, 0, 0); rst = 0;
    tick();
    checks++; if (count !== 0 || rf_we !== '0 || rf_wdata !== '0)
      begin failures++; $display("FAIL midrst_state got=%0d/%b/%h exp=0/0/0", count, rf_we, rf_wdata); end
    idle();
    tick();
    checks++; if (rf_we !== '0 || count !== 0)
      begin failures++; $display("FAIL midrst_after got=%b/%0d exp=0/0", rf_we, count); end
  endtask

  task automatic test_random();
    logic       h;
    logic [31:0] d;
    for (int it = 0; it < 400; it++) begin
      idle();
      in_valid = ($urandom_range(0, 3) != 0);
      in_kill  = ($urandom_range(0, 7) == 0);
      in_rd    = 5'($urandom_range(0, 7));
      in_data  = $urandom; in_hi = $urandom; in_lo = $urandom;
      in_rf_we = $urandom_range(0, 1);
      in_hi_we = ($urandom_range(0, 3) == 0);
      in_lo_we = ($urandom_range(0, 3) == 0);
      in_cp0_we = ($urandom_range(0, 5) == 0);
      in_cp0_addr = 5'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 39) != 0);
      q_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int j = 0; j < NQ; j++) begin
        exp_lookup(q_addr[j*5 +: 5], h, d);
        checks++; if (q_hit[j] !== h || (h && q_data[j*32 +: 32] !== d))
          begin failures++; $display("FAIL rand_lookup[%0d.%0d] got=%b/%h exp=%b/%h", it, j, q_hit[j], q_data[j*32 +: 32], h, d); end
      end
      checks++; if (in_ready !== (mq.size() < DEPTH))
        begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", it, in_ready, mq.size() < DEPTH); end
      tick();
      checks++; if (rf_we !== e_rf_we) begin failures++; $display("FAIL rand_rf_we[%0d] got=%b exp=%b", it, rf_we, e_rf_we); end
      for (int i = 0; i < RF_PORTS; i++) begin
        checks++; if (rf_waddr[i*5 +: 5] !== e_waddr[i] || rf_wdata[i*32 +: 32] !== e_wdata[i])
          begin failures++; $display("FAIL rand_port[%0d.%0d] got=%0d/%h exp=%0d/%h", it, i, rf_waddr[i*5 +: 5], rf_wdata[i*32 +: 32], e_waddr[i], e_wdata[i]); end
      end
      checks++; if ({hi_wena, lo_wena, cp0_wena} !== {e_hi_en, e_lo_en, e_cp0_en})
        begin failures++; $display("FAIL rand_spc_en[%0d] got=%b exp=%b", it, {hi_wena, lo_wena, cp0_wena}, {e_hi_en, e_lo_en, e_cp0_en}); end
      checks++; if (hi_wdata !== e_hi || lo_wdata !== e_lo || cp0_wdata !== e_cp0 || cp0_waddr !== e_cp0_addr)
        begin failures++; $display("FAIL rand_spc_data[%0d] got=%h/%h/%h/%0d exp=%h/%h/%h/%0d", it, hi_wdata, lo_wdata, cp0_wdata, cp0_waddr, e_hi, e_lo, e_cp0, e_cp0_addr); end
      checks++; if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
        begin failures++; $display("FAIL rand_count[%0d] got=%0d/%b/%b exp=%0d", it, count, empty, full, mq.size()); end
    end
  endtask

  initial begin
    idle();
    in_rd = 0; in_data = 0; in_hi = 0; in_lo = 0; in_cp0_addr = 0; q_addr = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_special();
    test_same_rd();
    test_flush();
    test_kill();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
